// File: rtl/param_cpu.sv
// Parametrised multicycle CPU: IDLE -> DECODE -> EXEC -> [MEM] -> WB, with an
// internal register file, data memory, zero/carry flags and a debug read port.
module param_cpu #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_BITS   = 5,
    parameter int REG_BITS    = 2,
    parameter int INSTR_WIDTH = 20
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INSTR_WIDTH-1:0] instruction,
    input  logic                   instr_valid,
    output logic                   instr_ready,
    output logic                   busy,
    output logic                   done,
    output logic                   flag_zero,
    output logic                   flag_carry,
    input  logic [REG_BITS-1:0]    dbg_sel,
    output logic [DATA_WIDTH-1:0]  dbg_data
);
    localparam int NREG  = 1 << REG_BITS;
    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;
    localparam logic [1:0] C_LI = 2'd0, C_ALU = 2'd1, C_LOAD = 2'd2, C_STORE = 2'd3;

    state_t                            state_q, state_d;
    logic [INSTR_WIDTH-1:0]            instr_q, instr_d;
    logic [DATA_WIDTH-1:0]             op_a_q, op_a_d, op_b_q, op_b_d, op_c_q, op_c_d;
    logic [DATA_WIDTH-1:0]             res_q, res_d;
    logic [ADDR_BITS-1:0]              addr_q, addr_d;
    logic                              carry_q, carry_d;
    logic                              flag_zero_q, flag_zero_d, flag_carry_q, flag_carry_d;
    logic                              ready_q, ready_d, busy_q, busy_d, done_q, done_d;
    logic [NREG-1:0][DATA_WIDTH-1:0]   regs_q, regs_d;
    logic [DEPTH-1:0][DATA_WIDTH-1:0]  mem_q, mem_d;

    logic [1:0]            cls;
    logic [REG_BITS-1:0]   x1, x2, x3;
    logic [7:0]            imm;
    logic [2:0]            func;
    logic                  unused_rsvd;

    assign cls         = instr_q[INSTR_WIDTH-1 -: 2];
    assign x1          = instr_q[INSTR_WIDTH-3 -: REG_BITS];
    assign x2          = instr_q[INSTR_WIDTH-3-REG_BITS -: REG_BITS];
    assign x3          = instr_q[INSTR_WIDTH-3-2*REG_BITS -: REG_BITS];
    assign imm         = instr_q[11:4];
    assign func        = instr_q[2:0];
    assign unused_rsvd = instr_q[3];

    logic [DATA_WIDTH:0]   sum_ext;
    logic [DATA_WIDTH-1:0] alu_res;
    logic                  alu_carry, lt;
    logic [ADDR_BITS-1:0]  eff_addr;

    always_comb begin
        sum_ext   = (DATA_WIDTH+1)'(op_a_q) + (DATA_WIDTH+1)'(op_b_q);
        lt        = op_a_q < op_b_q;
        alu_carry = 1'b0;
        alu_res   = '0;
        case (func)
            3'd0: begin alu_res = sum_ext[DATA_WIDTH-1:0]; alu_carry = sum_ext[DATA_WIDTH]; end
            3'd1: begin alu_res = op_a_q - op_b_q; alu_carry = lt; end
            3'd2: alu_res = op_a_q & op_b_q;
            3'd3: alu_res = op_a_q | op_b_q;
            3'd4: alu_res = op_a_q ^ op_b_q;
            3'd5: alu_res = {{(DATA_WIDTH-1){1'b0}}, lt};
            3'd6: alu_res = op_a_q << 1;
            default: alu_res = op_a_q >> 1;
        endcase
        // Modular add in ADDR_BITS is identical to a full-width add then truncate
        eff_addr = ADDR_BITS'(op_a_q) + ADDR_BITS'(imm);
    end

    always_comb begin
        state_d      = state_q;
        instr_d      = instr_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_c_d       = op_c_q;
        res_d        = res_q;
        addr_d       = addr_q;
        carry_d      = carry_q;
        flag_zero_d  = flag_zero_q;
        flag_carry_d = flag_carry_q;
        regs_d       = regs_q;
        mem_d        = mem_q;
        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    instr_d = instruction;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                op_a_d  = regs_q[x2];
                op_b_d  = regs_q[x3];
                op_c_d  = regs_q[x1];
                state_d = S_EXEC;
            end
            S_EXEC: begin
                case (cls)
                    C_LI:  begin res_d = DATA_WIDTH'(imm); state_d = S_WB; end
                    C_ALU: begin res_d = alu_res; carry_d = alu_carry; state_d = S_WB; end
                    default: begin addr_d = eff_addr; state_d = S_MEM; end
                endcase
            end
            S_MEM: begin
                if (cls == C_STORE) mem_d[addr_q] = op_c_q;
                else                res_d = mem_q[addr_q];
                state_d = S_WB;
            end
            S_WB: begin
                if (cls != C_STORE) regs_d[x1] = res_q;
                if (cls == C_ALU) begin
                    flag_zero_d  = (res_q == '0);
                    flag_carry_d = carry_q;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_WB);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            instr_q      <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_c_q       <= '0;
            res_q        <= '0;
            addr_q       <= '0;
            carry_q      <= 1'b0;
            flag_zero_q  <= 1'b0;
            flag_carry_q <= 1'b0;
            ready_q      <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= DATA_WIDTH'(i);
            mem_q        <= '0;
        end else begin
            state_q      <= state_d;
            instr_q      <= instr_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_c_q       <= op_c_d;
            res_q        <= res_d;
            addr_q       <= addr_d;
            carry_q      <= carry_d;
            flag_zero_q  <= flag_zero_d;
            flag_carry_q <= flag_carry_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            regs_q       <= regs_d;
            mem_q        <= mem_d;
        end
    end

    assign instr_ready = ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign flag_zero   = flag_zero_q;
    assign flag_carry  = flag_carry_q;
    assign dbg_data    = regs_q[dbg_sel];
endmodule

// File: tb/tb_param_cpu.sv
// Bench for param_cpu: instruction-level reference model with per-cycle output
// checks, directed sequences with literal expectations, and randomized traffic.
module tb_param_cpu;
    localparam int DW = 8, RB = 2, IW = 20, NREG = 4, DEPTH = 32, MASK = 255;

    logic          clk = 1'b0, rst = 1'b1;
    logic [IW-1:0] instruction = '0;
    logic          instr_valid = 1'b0;
    logic          instr_ready, busy, done, flag_zero, flag_carry;
    logic [RB-1:0] dbg_sel = '0;
    logic [DW-1:0] dbg_data;

    always #5 clk = ~clk;

    param_cpu #(.DATA_WIDTH(DW), .ADDR_BITS(5), .REG_BITS(RB), .INSTR_WIDTH(IW)) dut (
        .clk(clk), .rst(rst), .instruction(instruction), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .busy(busy), .done(done), .flag_zero(flag_zero),
        .flag_carry(flag_carry), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Instruction-level model: architectural state plus remaining busy cycles
    int            m_reg[NREG];
    int            m_mem[DEPTH];
    int            m_z, m_c, rem, m_done, dut_done;
    logic [IW-1:0] pend;
    bit            m_live = 0;

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) m_reg[i] = i % 256;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
        m_z = 0; m_c = 0; rem = 0;
    endtask

    task automatic model_commit(input logic [IW-1:0] ins);
        int cls, x1, x2, x3, imm, f, a, b, r;
        cls = int'(ins[19:18]); x1 = int'(ins[17:16]); x2 = int'(ins[15:14]);
        x3 = int'(ins[13:12]); imm = int'(ins[11:4]); f = int'(ins[2:0]);
        a = m_reg[x2]; b = m_reg[x3];
        case (cls)
            0: m_reg[x1] = imm & MASK;
            1: begin
                m_c = 0;
                case (f)
                    0: begin r = a + b; m_c = (r >> DW) & 1; end
                    1: begin r = a - b; m_c = (a < b) ? 1 : 0; end
                    2: r = a & b;
                    3: r = a | b;
                    4: r = a ^ b;
                    5: r = (a < b) ? 1 : 0;
                    6: r = a << 1;
                    default: r = a >> 1;
                endcase
                r = r & MASK;
                m_z = (r == 0) ? 1 : 0;
                m_reg[x1] = r;
            end
            2: m_reg[x1] = m_mem[(a + imm) % DEPTH];
            default: m_mem[(a + imm) % DEPTH] = m_reg[x1];
        endcase
    endtask

    always @(posedge clk) begin
        if (rst) begin
            model_reset();
            m_live = 1;
        end else if (m_live) begin
            if (rem == 0) begin
                if (instr_valid) begin
                    pend = instruction;
                    rem  = instruction[19] ? 4 : 3;
                end
            end else begin
                rem--;
                if (rem == 0) begin
                    model_commit(pend);
                    m_done++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("instr_ready", instr_ready, (rem == 0) ? 1 : 0);
            chk("busy", busy, (rem != 0) ? 1 : 0);
            chk("done", done, (rem == 1) ? 1 : 0);
            chk("flag_zero", flag_zero, m_z);
            chk("flag_carry", flag_carry, m_c);
            chk("dbg_data", dbg_data, m_reg[dbg_sel]);
            if (done === 1'b1) dut_done++;
        end
    end

    task automatic run(input logic [IW-1:0] ins, input int exp_lat);
        int n;
        n = 0;
        while (instr_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        instruction = ins;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        instruction = IW'($urandom);
        n = 1;
        while (instr_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        chk("latency", n, exp_lat);
    endtask

    task automatic chk_reg(input int idx, input int exp);
        dbg_sel = RB'(idx);
        #1;
        chk("reg_literal", dbg_data, exp);
    endtask

    initial begin
        int d0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_ready", instr_ready, 1); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
        chk("rst_z", flag_zero, 0); chk("rst_c", flag_carry, 0);
        for (int i = 0; i < NREG; i++) chk_reg(i, i);

        run(20'h47000, 4); chk_reg(0, 4); chk("add_z", flag_zero, 0); chk("add_c", flag_carry, 0);
        run(20'h72001, 4); chk_reg(3, 2); chk("sub_c", flag_carry, 0);
        run(20'h4B001, 4); chk_reg(0, 0); chk("sub_z", flag_zero, 1);
        run(20'hD80F0, 5); run(20'hB80F0, 5); chk_reg(3, 1);
        run(20'hD8FF0, 5); run(20'h84000, 5); chk_reg(0, 1);
        run(20'h00C80, 4); chk_reg(0, 200);
        run(20'h10640, 4); chk_reg(1, 100);
        run(20'h61000, 4); chk_reg(2, 44); chk("ovf_c", flag_carry, 1); chk("ovf_z", flag_zero, 0);
        run(20'h74005, 4); chk_reg(3, 1); chk("sltu_c", flag_carry, 0);
        run(20'h70006, 4); chk_reg(3, 144);
        run(20'h70007, 4); chk_reg(3, 100);
        run(20'h71004, 4); chk_reg(3, 172);

        // Abort an ADD in EXEC
        d0 = dut_done;
        instruction = 20'h47000; instr_valid = 1'b1;
        @(posedge clk); #1 instr_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < NREG; i++) chk_reg(i, i);
        chk("abort_busy", busy, 0); chk("abort_ready", instr_ready, 1);
        chk("abort_z", flag_zero, 0); chk("abort_c", flag_carry, 0);
        repeat (3) @(posedge clk);
        #1 chk("abort_no_done", dut_done, d0);
        run(20'hB80F0, 5); chk_reg(3, 0);
        run(20'hB8FF0, 5); chk_reg(3, 0);

        // Reset and valid together: nothing accepted
        rst = 1'b1; instr_valid = 1'b1; instruction = 20'h47000;
        @(posedge clk); #1 rst = 1'b0; instr_valid = 1'b0;
        chk("rstv_busy", busy, 0);
        @(posedge clk); #1 chk("rstv_busy2", busy, 0); chk_reg(0, 0);

        // Randomized traffic with valid mostly held and instruction changing
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(posedge clk); #1;
            instr_valid = ($urandom_range(0, 3) != 0);
            instruction = IW'($urandom);
            dbg_sel     = RB'($urandom);
            rst         = ($urandom_range(0, 199) == 0 && rem != 1);
        end
        @(posedge clk); #1 rst = 1'b0; instr_valid = 1'b0;
        for (int n = 0; n < 20 && instr_ready !== 1'b1; n++) begin @(posedge clk); #1; end
        chk("drain_ready", instr_ready, 1);
        @(negedge clk); #1;
        chk("done_count", dut_done, m_done);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
